// File: rtl/dmem_responder_pkg.sv
// Purpose: shared word width, wait-counter width and FSM state encodings
//          for the data-memory responder.
// Ports  : none (package).
package dmem_responder_pkg;

   localparam int unsigned DMEM_WORD  = 64;
   localparam int unsigned DMEM_CNT_W = 4;
   localparam int unsigned DMEM_ERR_W = 16;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Purpose: DEPTH x WORD register array with one synchronous write port,
//          one combinational read port and asynchronous clear.
// Ports  : clk, reset       - clock, async active-high clear
//          i_we             - write enable
//          i_waddr, i_wdata - write index and data
//          i_raddr, o_rdata - read index and combinational read data
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned WORD  = DMEM_WORD,
   parameter int unsigned DEPTH = 32
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WORD-1:0]          i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WORD-1:0]          o_rdata
);

   logic [WORD-1:0] r_mem [DEPTH];

   // Storage words with whole-array clear on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Purpose: valid/ready data-memory responder with programmable wait states,
//          access checking and a saturating error counter.
// Ports  : clk, reset                    - clock, async active-high reset
//          req_valid/req_ready           - request handshake
//          req_write, req_addr, req_wdata - request payload (byte address)
//          rsp_valid/rsp_ready           - response handshake
//          rsp_rdata, rsp_err            - response payload
//          err_count                     - saturating error-response count
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned WORD    = DMEM_WORD,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 2
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [WORD-1:0]       req_addr,
   input  logic [WORD-1:0]       req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD-1:0]       rsp_rdata,
   output logic                  rsp_err,
   output logic [DMEM_ERR_W-1:0] err_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [DMEM_CNT_W-1:0] LAT_M1 =
      (LATENCY > 0) ? DMEM_CNT_W'(LATENCY - 1) : '0;

   dmem_state_e           r_state;
   dmem_state_e           w_state_next;
   logic [DMEM_CNT_W-1:0] r_cnt;
   logic                  r_write;
   logic [WORD-1:0]       r_addr;
   logic [WORD-1:0]       r_wdata;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [WORD-1:0]       r_rsp_rdata;
   logic [DMEM_ERR_W-1:0] r_err_count;

   logic                  w_accept;
   logic                  w_done;
   logic                  w_enter_resp;
   logic                  w_cur_write;
   logic [WORD-1:0]       w_cur_addr;
   logic [WORD-1:0]       w_cur_wdata;
   logic [AW-1:0]         w_index;
   logic                  w_err;
   logic                  w_mem_we;
   logic [WORD-1:0]       w_mem_rdata;

   assign req_ready = (r_state == DMEM_IDLE) && !reset;
   assign w_accept  = req_valid && req_ready;
   assign w_done    = r_rsp_valid && rsp_ready;

   // With zero wait states RESP is entered on the accept edge itself, so the
   // check and the array access must see the live request, not the latch.
   assign w_cur_write = (r_state == DMEM_IDLE) ? req_write : r_write;
   assign w_cur_addr  = (r_state == DMEM_IDLE) ? req_addr  : r_addr;
   assign w_cur_wdata = (r_state == DMEM_IDLE) ? req_wdata : r_wdata;

   assign w_index  = w_cur_addr[AW+2:3];
   assign w_err    = (w_cur_addr[2:0] != 3'd0) || (w_cur_addr[WORD-1:AW+3] != '0);
   assign w_mem_we = w_enter_resp && w_cur_write && !w_err;

   dmem_array #(
      .WORD  (WORD),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_mem_we),
      .i_waddr (w_index),
      .i_wdata (w_cur_wdata),
      .i_raddr (w_index),
      .o_rdata (w_mem_rdata)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= DMEM_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_enter_resp = 1'b0;
      case (r_state)
         DMEM_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 0) begin
                  w_state_next = DMEM_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_next = DMEM_WAIT;
               end
            end
         end
         DMEM_WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = DMEM_RESP;
               w_enter_resp = 1'b1;
            end
         end
         DMEM_RESP: begin
            if (w_done) w_state_next = DMEM_IDLE;
         end
         default: w_state_next = DMEM_IDLE;
      endcase
   end

   // Request latch, wait counter and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_err_count <= '0;
      end else begin
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= LAT_M1;
         end else if ((r_state == DMEM_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DMEM_CNT_W'(1);
         end

         if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || w_cur_write) ? '0 : w_mem_rdata;
            if (w_err && (r_err_count != '1))
               r_err_count <= r_err_count + DMEM_ERR_W'(1);
         end else if (w_done) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: scoreboard bench for dmem_responder; one instance with two wait
//          states and one with none, sharing clock and reset.
// Ports  : none (top-level bench).
module tb_dmem_responder;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [63:0] req_addr, req_wdata, rsp_rdata;
   logic [15:0] err_count;
   logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [63:0] req_addr0, req_wdata0, rsp_rdata0;
   logic [15:0] err_count0;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   exp_t q0[$];

   always #5 clk = ~clk;

   dmem_responder #(.WORD(64), .DEPTH(32), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
   );

   dmem_responder #(.WORD(64), .DEPTH(32), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_wdata(req_wdata0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .err_count(err_count0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Issue one request; optionally wait for the response (and its handshake
   // if rsp_ready is high). lat = negedges from accept edge to rsp_valid.
   task automatic issue(input int sel, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] er, input logic ee,
                        input bit wait_rsp, output int lat, output time t_acc);
      int   n;
      exp_t e;
      lat = -1;
      e.rdata = er;
      e.err   = ee;
      @(negedge clk);
      if (sel == 0) begin
         req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      end else begin
         req_valid0 = 1'b1; req_write0 = w; req_addr0 = a; req_wdata0 = d;
      end
      n = 0;
      while (((sel == 0) ? !req_ready : !req_ready0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail("req_ready_timeout");
      if (sel == 0) q.push_back(e);
      else          q0.push_back(e);
      @(posedge clk);
      t_acc = $time;
      #1;
      req_valid  = 1'b0;
      req_valid0 = 1'b0;
      if (wait_rsp) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (((sel == 0) ? !rsp_valid : !rsp_valid0) && n < 50);
         if (n >= 50) fail("rsp_valid_timeout");
         lat = n;
         if ((sel == 0) ? rsp_ready : rsp_ready0) @(posedge clk);
      end
   endtask

   // Scoreboard monitors: compare whenever a response handshake is pending
   always @(negedge clk) begin
      exp_t e;
      if (!reset && rsp_valid && rsp_ready) begin
         if (q.size() == 0) fail("unexpected_rsp");
         else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && rsp_valid0 && rsp_ready0) begin
         if (q0.size() == 0) fail("unexpected_rsp0");
         else begin
            e = q0.pop_front();
            chk("rsp0_rdata", rsp_rdata0, e.rdata);
            chk("rsp0_err", 64'(rsp_err0), 64'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      time t1, t2, t3;
      reset = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
      req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 1;
      repeat (2) @(negedge clk);
      chk("req_ready_in_reset", 64'(req_ready), 64'd0);
      reset = 1'b0;
      #1;
      chk("req_ready_after_reset", 64'(req_ready), 64'd1);
      chk("rsp_valid_reset", 64'(rsp_valid), 64'd0);
      chk("rsp_rdata_reset", rsp_rdata, 64'd0);
      chk("err_count_reset", 64'(err_count), 64'd0);

      // Store then load, latency and spacing at two wait states
      issue(0, 1, 64'h10, 64'hDEADBEEF_00000001, 64'd0, 0, 1, lat, t1);
      chk("store_latency", 64'(lat), 64'd3);
      issue(0, 0, 64'h10, 64'd0, 64'hDEADBEEF_00000001, 0, 1, lat, t2);
      chk("load_latency", 64'(lat), 64'd3);
      chk("spacing_lat2", 64'(t2 - t1), 64'd40);

      // Error accesses and address boundaries
      issue(0, 0, 64'h0C, 64'd0, 64'd0, 1, 1, lat, t1);
      issue(0, 0, 64'h100, 64'd0, 64'd0, 1, 1, lat, t1);
      @(negedge clk);
      chk("err_count_2", 64'(err_count), 64'd2);
      issue(0, 0, 64'h08, 64'd0, 64'd0, 0, 1, lat, t1);
      issue(0, 1, 64'hF8, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 1, lat, t1);
      issue(0, 0, 64'hF8, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 1, lat, t1);
      issue(0, 1, 64'hFF, 64'hFFFF, 64'd0, 1, 1, lat, t1);
      issue(0, 0, 64'hF8, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 1, lat, t1);
      @(negedge clk);
      chk("err_count_3", 64'(err_count), 64'd3);

      // Backpressure: response held, extra request ignored
      rsp_ready = 1'b0;
      issue(0, 0, 64'h10, 64'd0, 64'hDEADBEEF_00000001, 0, 1, lat, t1);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'hAAAA;
         end
         if (i == 3) req_valid = 1'b0;
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_rdata", rsp_rdata, 64'hDEADBEEF_00000001);
         chk("hold_err", 64'(rsp_err), 64'd0);
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_extra_rsp", 64'(rsp_valid), 64'd0);
      chk("queue_drained", 64'(q.size()), 64'd0);
      issue(0, 0, 64'h18, 64'd0, 64'd0, 0, 1, lat, t1);

      // Reset during the wait phase of a store
      issue(0, 1, 64'h20, 64'h5555, 64'd0, 0, 0, lat, t1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      chk("midrst_err_count", 64'(err_count), 64'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 64'd0);
      q.delete();
      q0.delete();
      @(negedge clk);
      reset = 1'b0;
      issue(0, 0, 64'h20, 64'd0, 64'd0, 0, 1, lat, t1);
      issue(0, 0, 64'h10, 64'd0, 64'd0, 0, 1, lat, t1);
      @(negedge clk);
      chk("post_rst_err_count", 64'(err_count), 64'd0);

      // Zero wait states: back-to-back stores then load
      issue(1, 1, 64'hF8, 64'h1111, 64'd0, 0, 1, lat, t1);
      chk("lat0_store1", 64'(lat), 64'd1);
      issue(1, 1, 64'hF8, 64'h2222, 64'd0, 0, 1, lat, t2);
      chk("lat0_store2", 64'(lat), 64'd1);
      issue(1, 0, 64'hF8, 64'd0, 64'h2222, 0, 1, lat, t3);
      chk("lat0_load", 64'(lat), 64'd1);
      chk("lat0_spacing_a", 64'(t2 - t1), 64'd20);
      chk("lat0_spacing_b", 64'(t3 - t2), 64'd20);
      issue(1, 0, 64'h100, 64'd0, 64'd0, 1, 1, lat, t1);
      repeat (2) @(negedge clk);
      chk("lat0_err_count", 64'(err_count0), 64'd1);
      chk("queues_empty", 64'(q.size() + q0.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
